// File: rtl/ir_keyboard_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ir_keyboard_receiver
// Description : Decodes the PCjr IR keyboard biphase stream into scan-code
//               bytes with start-edge timing recovery and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_keyboard_receiver #(
    parameter logic [15:0] BIT_CELL_CYCLES = 16'd22000,
    parameter logic [15:0] RECOVER_CYCLES  = 16'd44000,
    parameter logic        INVERT_INPUT    = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ir_signal,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [15:0] c_S1_POINT  = BIT_CELL_CYCLES / 16'd4;
    localparam logic [31:0] c_S2_WIDE   = (32'd3 * {16'd0, BIT_CELL_CYCLES}) / 32'd4;
    localparam logic [15:0] c_S2_POINT  = c_S2_WIDE[15:0];
    localparam logic [15:0] c_STOP_PT   = BIT_CELL_CYCLES / 16'd2;
    localparam logic [15:0] c_CELL_LAST = BIT_CELL_CYCLES - 16'd1;
    localparam logic [15:0] c_IDLE_LAST = RECOVER_CYCLES - 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_l_prev;
    logic [15:0] r_cell_cnt;
    logic [15:0] r_idle_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_s1;
    logic [7:0]  r_shift;
    logic        r_parity;

    logic w_line;
    logic w_start_edge;
    logic w_cell_end;
    logic w_s1_hit;
    logic w_s2_hit;
    logic w_stop_hit;
    logic w_biphase_bad;
    logic w_in_frame;
    logic w_frame_err;
    logic w_frame_done;

    assign w_line        = r_sync2;
    assign w_start_edge  = !r_l_prev && w_line;
    assign w_cell_end    = (r_cell_cnt == c_CELL_LAST);
    assign w_s1_hit      = (r_cell_cnt == c_S1_POINT);
    assign w_s2_hit      = (r_cell_cnt == c_S2_POINT);
    assign w_stop_hit    = (r_cell_cnt == c_STOP_PT);
    assign w_biphase_bad = w_s2_hit && (r_s1 == w_line);
    assign w_in_frame    = (r_state == ST_START) || (r_state == ST_DATA) ||
                           (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign busy          = (r_state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_s2_hit && (!r_s1 || w_line)) w_frame_err = 1'b1;
                else if (w_cell_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_biphase_bad) w_frame_err = 1'b1;
                else if (w_cell_end && (r_bit_idx == 3'd7)) w_state_next = ST_PARITY;
            end
            ST_PARITY: begin
                if (w_biphase_bad) w_frame_err = 1'b1;
                else if (w_cell_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_stop_hit) begin
                    if (w_line) begin
                        w_frame_err = 1'b1;
                    end else begin
                        w_frame_done = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                if (!w_line && (r_idle_cnt == c_IDLE_LAST)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_frame_err) w_state_next = ST_RECOVER;
    end

    // Synchronizer and edge history reset high: a line already high at
    // release must first drop low before a start edge can be seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_l_prev      <= 1'b1;
            r_cell_cnt    <= 16'd0;
            r_idle_cnt    <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_s1          <= 1'b0;
            r_shift       <= 8'h00;
            r_parity      <= 1'b0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_sync1  <= ir_signal ^ INVERT_INPUT;
            r_sync2  <= r_sync1;
            r_l_prev <= w_line;

            if (w_in_frame && !w_frame_err && !w_frame_done) begin
                r_cell_cnt <= w_cell_end ? 16'd0 : r_cell_cnt + 16'd1;
            end else begin
                r_cell_cnt <= 16'd0;
            end

            if ((r_state == ST_RECOVER) && !w_line && (w_state_next == ST_RECOVER)) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end else begin
                r_idle_cnt <= 16'd0;
            end

            if (r_state == ST_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_cell_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_s1_hit) r_s1 <= w_line;

            if (w_frame_err) begin
                r_shift <= 8'h00;
            end else if ((r_state == ST_DATA) && w_s2_hit) begin
                r_shift[r_bit_idx] <= r_s1;
            end

            if ((r_state == ST_PARITY) && w_s2_hit) r_parity <= r_s1;

            if (w_frame_done) data_out <= r_shift;
            data_valid    <= w_frame_done && (^{r_shift, r_parity});
            parity_error  <= w_frame_done && !(^{r_shift, r_parity});
            framing_error <= w_frame_err;
        end
    end

endmodule
`default_nettype wire
